regfile_write_arbiter: RTL and testbench

Shares the register file's single write port (reg_d_enable/reg_d/reg_d_value) between two writeback sources: the ALU result path and the data-memory load path.
- Arbitrates between them round-robin.
- Registers the chosen write toward the register file.
- Keeps a pending-load scoreboard so decode can detect RAW hazards on operands A/B and the ALU cannot overtake an outstanding load to the same register.

---
 rtl/regfile_write_arbiter_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 51 +++++
 rtl/regfile_write_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared configuration for the register-file write arbiter slice.
// Holds default data/register-file sizes and the grant encoding used by
// the round-robin arbiter.
package regfile_write_arbiter_pkg;

   localparam int unsigned DMEM_DATA_WIDTH = 16;
   localparam int unsigned REGS_COUNT      = 16;

   typedef enum logic {
      GRANT_ALU = 1'b0,
      GRANT_MEM = 1'b1
   } grant_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register, set when a
// load is issued and cleared when that load's data is written back.
// Ports:
//   clock, nreset       clock / asynchronous active-low reset
//   i_set, i_set_reg    issued load marks its destination pending
//   i_clr, i_clr_reg    accepted load writeback clears its destination
//   i_rd_a, i_rd_b      decode operand indices
//   o_hit_a, o_hit_b    pending state of the decode operands
//   o_pending           full scoreboard vector
module regfile_scoreboard #(
   parameter int unsigned REGS_COUNT = regfile_write_arbiter_pkg::REGS_COUNT,
   parameter int unsigned REG_AW     = 4
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  logic                  i_set,
   input  logic [REG_AW-1:0]     i_set_reg,
   input  logic                  i_clr,
   input  logic [REG_AW-1:0]     i_clr_reg,
   input  logic [REG_AW-1:0]     i_rd_a,
   input  logic [REG_AW-1:0]     i_rd_b,
   output logic                  o_hit_a,
   output logic                  o_hit_b,
   output logic [REGS_COUNT-1:0] o_pending
);
   import regfile_write_arbiter_pkg::*;

   logic [REGS_COUNT-1:0] r_pending;
   logic [REGS_COUNT-1:0] w_set_mask;
   logic [REGS_COUNT-1:0] w_clr_mask;

   // Register 0 is hard-wired, so it can never be pending.
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (i_set && (i_set_reg != '0)) w_set_mask[i_set_reg] = 1'b1;
      if (i_clr)                      w_clr_mask[i_clr_reg] = 1'b1;
   end

   // Set is applied after clear so a new load issued on the same edge as the
   // old one's writeback keeps the register pending.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) r_pending <= '0;
      else         r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
   end

   assign o_hit_a   = r_pending[i_rd_a];
   assign o_hit_b   = r_pending[i_rd_b];
   assign o_pending = r_pending;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the ALU writeback
// path and the data-memory load path using round-robin arbitration, and
// registers the granted write toward the register file.
// Ports:
//   clock, nreset                         clock / asynchronous active-low reset
//   alu_valid/alu_ready/alu_reg/alu_value ALU writeback request (valid/ready)
//   mem_valid/mem_ready/mem_reg/mem_value load writeback request (valid/ready)
//   pend_set, pend_reg                    issued load destination
//   reg_a, reg_b, hazard_a, hazard_b      decode RAW hazard lookup
//   pending                               scoreboard vector
//   reg_d_enable, reg_d, reg_d_value      registered register-file write
module regfile_write_arbiter #(
   parameter int unsigned DATA_WIDTH = regfile_write_arbiter_pkg::DMEM_DATA_WIDTH,
   parameter int unsigned REGS_COUNT = regfile_write_arbiter_pkg::REGS_COUNT,
   parameter int unsigned REG_AW     = 4
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [REG_AW-1:0]     alu_reg,
   input  logic [DATA_WIDTH-1:0] alu_value,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [REG_AW-1:0]     mem_reg,
   input  logic [DATA_WIDTH-1:0] mem_value,
   input  logic                  pend_set,
   input  logic [REG_AW-1:0]     pend_reg,
   input  logic [REG_AW-1:0]     reg_a,
   input  logic [REG_AW-1:0]     reg_b,
   output logic                  hazard_a,
   output logic                  hazard_b,
   output logic [REGS_COUNT-1:0] pending,
   output logic                  reg_d_enable,
   output logic [REG_AW-1:0]     reg_d,
   output logic [DATA_WIDTH-1:0] reg_d_value
);
   import regfile_write_arbiter_pkg::*;

   grant_e                r_last_grant;
   grant_e                w_last_grant_nxt;
   logic                  w_alu_elig;
   logic                  w_mem_elig;
   logic                  w_alu_grant;
   logic                  w_mem_grant;
   logic [REGS_COUNT-1:0] w_pending;

   logic                  r_d_enable;
   logic [REG_AW-1:0]     r_d;
   logic [DATA_WIDTH-1:0] r_d_value;

   regfile_scoreboard #(
      .REGS_COUNT (REGS_COUNT),
      .REG_AW     (REG_AW)
   ) u_scoreboard (
      .clock     (clock),
      .nreset    (nreset),
      .i_set     (pend_set),
      .i_set_reg (pend_reg),
      .i_clr     (w_mem_grant),
      .i_clr_reg (mem_reg),
      .i_rd_a    (reg_a),
      .i_rd_b    (reg_b),
      .o_hit_a   (hazard_a),
      .o_hit_b   (hazard_b),
      .o_pending (w_pending)
   );

   // The ALU must not overtake an outstanding load to its destination.
   assign w_alu_elig = alu_valid && !w_pending[alu_reg];
   assign w_mem_elig = mem_valid;

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) r_last_grant <= GRANT_MEM;
      else         r_last_grant <= w_last_grant_nxt;
   end

   always_comb begin
      w_alu_grant      = 1'b0;
      w_mem_grant      = 1'b0;
      w_last_grant_nxt = r_last_grant;
      if (nreset) begin
         if (w_alu_elig && w_mem_elig) begin
            if (r_last_grant == GRANT_MEM) w_alu_grant = 1'b1;
            else                           w_mem_grant = 1'b1;
         end else begin
            w_alu_grant = w_alu_elig;
            w_mem_grant = w_mem_elig;
         end
         if (w_alu_grant)      w_last_grant_nxt = GRANT_ALU;
         else if (w_mem_grant) w_last_grant_nxt = GRANT_MEM;
      end
   end

   assign alu_ready = w_alu_grant;
   assign mem_ready = w_mem_grant;

   // Writes to register 0 are consumed but never reach the register file;
   // destination/data hold their last written values when idle.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_d_enable <= 1'b0;
         r_d        <= '0;
         r_d_value  <= '0;
      end else begin
         r_d_enable <= 1'b0;
         if (w_alu_grant && (alu_reg != '0)) begin
            r_d_enable <= 1'b1;
            r_d        <= alu_reg;
            r_d_value  <= alu_value;
         end else if (w_mem_grant && (mem_reg != '0)) begin
            r_d_enable <= 1'b1;
            r_d        <= mem_reg;
            r_d_value  <= mem_value;
         end
      end
   end

   assign pending      = w_pending;
   assign reg_d_enable = r_d_enable;
   assign reg_d        = r_d;
   assign reg_d_value  = r_d_value;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed stimulus, a transaction-level
// model compared every negedge, and literal expectations at key points.
module tb_regfile_write_arbiter;

   logic        clock = 1'b0;
   logic        nreset;
   logic        alu_valid, mem_valid, pend_set;
   logic        alu_ready, mem_ready;
   logic [3:0]  alu_reg, mem_reg, pend_reg, reg_a, reg_b;
   logic [15:0] alu_value, mem_value;
   logic        hazard_a, hazard_b;
   logic [15:0] pending;
   logic        reg_d_enable;
   logic [3:0]  reg_d;
   logic [15:0] reg_d_value;

   int checks = 0;
   int errors = 0;

   regfile_write_arbiter #(
      .DATA_WIDTH (16),
      .REGS_COUNT (16),
      .REG_AW     (4)
   ) dut (
      .clock        (clock),
      .nreset       (nreset),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_reg      (alu_reg),
      .alu_value    (alu_value),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_reg      (mem_reg),
      .mem_value    (mem_value),
      .pend_set     (pend_set),
      .pend_reg     (pend_reg),
      .reg_a        (reg_a),
      .reg_b        (reg_b),
      .hazard_a     (hazard_a),
      .hazard_b     (hazard_b),
      .pending      (pending),
      .reg_d_enable (reg_d_enable),
      .reg_d        (reg_d),
      .reg_d_value  (reg_d_value)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   bit [15:0] m_pend;
   bit        m_last_mem;
   bit        m_en;
   bit [3:0]  m_d;
   bit [15:0] m_val;

   // {alu_accepted, mem_accepted} for the current inputs
   function automatic bit [1:0] exp_rdy();
      bit a_ok, m_ok;
      if (nreset !== 1'b1) return 2'b00;
      a_ok = (alu_valid === 1'b1) && !m_pend[alu_reg];
      m_ok = (mem_valid === 1'b1);
      if (a_ok && m_ok) return m_last_mem ? 2'b10 : 2'b01;
      return {a_ok, m_ok};
   endfunction

   always @(posedge clock or negedge nreset) begin
      bit [1:0] g;
      if (!nreset) begin
         m_pend = '0; m_last_mem = 1'b1; m_en = 1'b0; m_d = '0; m_val = '0;
      end else begin
         g = exp_rdy();
         m_en = 1'b0;
         if (g[1]) begin
            m_last_mem = 1'b0;
            if (alu_reg != 0) begin m_en = 1'b1; m_d = alu_reg; m_val = alu_value; end
         end else if (g[0]) begin
            m_last_mem = 1'b1;
            m_pend[mem_reg] = 1'b0;
            if (mem_reg != 0) begin m_en = 1'b1; m_d = mem_reg; m_val = mem_value; end
         end
         if (pend_set && pend_reg != 0) m_pend[pend_reg] = 1'b1;
      end
   end

   // consumer register file, sampling on the negedge
   logic [15:0] tb_rf [16];
   always @(negedge clock) if (reg_d_enable === 1'b1) tb_rf[reg_d] <= reg_d_value;

   // per-cycle comparison against the model
   always @(negedge clock) begin
      bit [1:0] g;
      g = exp_rdy();
      chk("cmp_alu_ready", alu_ready, g[1]);
      chk("cmp_mem_ready", mem_ready, g[0]);
      chk("cmp_pending", pending, m_pend);
      chk("cmp_hazard_a", hazard_a, m_pend[reg_a]);
      chk("cmp_hazard_b", hazard_b, m_pend[reg_b]);
      chk("cmp_reg_d_enable", reg_d_enable, m_en);
      chk("cmp_reg_d", reg_d, m_d);
      chk("cmp_reg_d_value", reg_d_value, m_val);
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   int          exp_d   [4] = '{2, 5, 2, 5};
   logic [15:0] exp_val [4] = '{16'h1000, 16'h2000, 16'h1001, 16'h2001};

   initial begin
      nreset = 1'b0;
      alu_valid = 0; mem_valid = 0; pend_set = 0;
      alu_reg = 0; mem_reg = 0; pend_reg = 0; reg_a = 0; reg_b = 0;
      alu_value = 0; mem_value = 0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_en", reg_d_enable, 0);
      chk("reset_value", reg_d_value, 0);
      chk("reset_pending", pending, 0);
      nreset = 1'b1;

      // contention: both valid, grants alternate starting with the ALU
      cyc();
      alu_valid = 1; alu_reg = 2; alu_value = 16'h1000;
      mem_valid = 1; mem_reg = 5; mem_value = 16'h2000;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("cont_alu_ready", alu_ready, (k % 2) == 0);
         chk("cont_mem_ready", mem_ready, (k % 2) == 1);
         cyc();
         if (k % 2 == 0) alu_value = alu_value + 1;
         else            mem_value = mem_value + 1;
         chk("cont_reg_d", reg_d, exp_d[k]);
         chk("cont_value", reg_d_value, exp_val[k]);
      end
      alu_valid = 0; mem_valid = 0;

      // single ALU write to r3
      cyc();
      alu_valid = 1; alu_reg = 3; alu_value = 16'h00AB;
      #1 chk("single_ready", alu_ready, 1);
      cyc();
      alu_valid = 0;
      chk("single_en", reg_d_enable, 1);
      chk("single_reg_d", reg_d, 3);
      chk("single_value", reg_d_value, 16'h00AB);
      @(negedge clock); #1;
      chk("single_rf3", tb_rf[3], 16'h00AB);

      // scoreboard blocks ALU to a register with an outstanding load
      cyc();
      pend_set = 1; pend_reg = 7;
      cyc();
      pend_set = 0;
      alu_valid = 1; alu_reg = 7; alu_value = 16'h0A1A; reg_a = 7;
      #1;
      chk("sb_alu_blocked0", alu_ready, 0);
      chk("sb_hazard_a0", hazard_a, 1);
      cyc();
      chk("sb_alu_blocked1", alu_ready, 0);
      chk("sb_hazard_a1", hazard_a, 1);
      mem_valid = 1; mem_reg = 7; mem_value = 16'h0F0F;
      #1;
      chk("sb_mem_ready", mem_ready, 1);
      chk("sb_alu_still_blocked", alu_ready, 0);
      cyc();
      mem_valid = 0;
      #1;
      chk("sb_mem_reg_d", reg_d, 7);
      chk("sb_mem_value", reg_d_value, 16'h0F0F);
      chk("sb_hazard_cleared", hazard_a, 0);
      chk("sb_alu_now_ready", alu_ready, 1);
      cyc();
      alu_valid = 0;
      chk("sb_alu_value", reg_d_value, 16'h0A1A);
      @(negedge clock); #1;
      chk("sb_rf7_final", tb_rf[7], 16'h0A1A);

      // same-edge set and clear of r4: set wins
      cyc();
      mem_valid = 1; mem_reg = 4; mem_value = 16'h4444;
      pend_set = 1; pend_reg = 4; reg_b = 4;
      #1 chk("same_mem_ready", mem_ready, 1);
      cyc();
      mem_valid = 0; pend_set = 0;
      #1;
      chk("same_pend4", pending[4], 1);
      chk("same_hazard_b", hazard_b, 1);
      chk("same_value", reg_d_value, 16'h4444);
      mem_valid = 1; mem_value = 16'h5555;
      cyc();
      mem_valid = 0;
      #1 chk("same_cleared", pending, 0);

      // register 0: accepted, not written; pend_set to r0 ignored
      alu_valid = 1; alu_reg = 0; alu_value = 16'hDEAD;
      pend_set = 1; pend_reg = 0;
      #1 chk("zero_ready", alu_ready, 1);
      cyc();
      alu_valid = 0; pend_set = 0;
      #1;
      chk("zero_en", reg_d_enable, 0);
      chk("zero_reg_d_held", reg_d, 4);
      chk("zero_value_held", reg_d_value, 16'h5555);
      chk("zero_pending", pending, 0);
      alu_valid = 1; alu_reg = 1; alu_value = 16'h0111;
      mem_valid = 1; mem_reg = 2; mem_value = 16'h0222;
      #1;
      chk("zero_last_alu_mem_rdy", mem_ready, 1);
      chk("zero_last_alu_alu_rdy", alu_ready, 0);
      cyc();
      mem_valid = 0;
      #1 chk("zero_alu_after", alu_ready, 1);
      cyc();
      alu_valid = 0;

      // asynchronous reset in the middle of a transfer
      pend_set = 1; pend_reg = 6; reg_a = 6;
      cyc();
      pend_set = 0;
      alu_valid = 1; alu_reg = 9; alu_value = 16'h9999;
      cyc();
      #1 nreset = 1'b0;
      #1;
      chk("mid_rst_en", reg_d_enable, 0);
      chk("mid_rst_reg_d", reg_d, 0);
      chk("mid_rst_value", reg_d_value, 0);
      chk("mid_rst_pending", pending, 0);
      chk("mid_rst_alu_ready", alu_ready, 0);
      chk("mid_rst_mem_ready", mem_ready, 0);
      chk("mid_rst_hazard_a", hazard_a, 0);
      @(posedge clock);
      #3 nreset = 1'b1;
      #1 chk("post_rst_alu_ready", alu_ready, 1);
      cyc();
      alu_valid = 0;
      chk("post_rst_reg_d", reg_d, 9);

      repeat (2) cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
